// File: rtl/ppu_bg_addr_gen.sv
// PPU loopy scroll/address counters and background tile fetch sequencer.
// Drives the VRAM address and hands each fetched tile's attribute/pattern bytes downstream.
module ppu_bg_addr_gen (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [2:0]  fv_in,
    input  logic [4:0]  vt_in,
    input  logic        v_in,
    input  logic        h_in,
    input  logic [4:0]  ht_in,
    input  logic        upd_cntrs_in,
    input  logic        inc_addr_in,
    input  logic        inc_addr_amt_in,
    input  logic        bg_pt_sel_in,
    input  logic        render_en_in,
    input  logic        pix_pulse_in,
    input  logic [9:0]  nes_x_in,
    input  logic [9:0]  nes_y_in,
    input  logic [7:0]  vram_d_in,
    output logic [13:0] vram_a_out,
    output logic [1:0]  at_out,
    output logic [7:0]  ptl_out,
    output logic [7:0]  pth_out,
    output logic        tile_valid_out
);

    // phase    | fetch presented on vram_a_out (nes_x[2:1])
    // PH_NT    | nametable byte
    // PH_AT    | attribute byte
    // PH_PTL   | pattern low plane
    // PH_PTH   | pattern high plane
    typedef enum logic [1:0] {PH_NT, PH_AT, PH_PTL, PH_PTH} phase_t;

    logic [2:0]  q_fv, d_fv;
    logic        q_v, d_v;
    logic        q_h, d_h;
    logic [4:0]  q_vt, d_vt;
    logic [4:0]  q_ht, d_ht;

    logic [7:0]  nt_byte;
    logic [1:0]  at_byte;
    logic [7:0]  ptl_tmp;

    logic        active;
    logic        fetch_win;
    logic        fetch_step;
    phase_t      phase;
    logic [14:0] comp;
    logic [14:0] comp_inc;
    logic [7:0]  at_shifted;

    assign active     = render_en_in && ((nes_y_in <= 10'd239) || (nes_y_in == 10'd261));
    assign fetch_win  = (nes_x_in <= 10'd255) || ((nes_x_in >= 10'd320) && (nes_x_in <= 10'd335));
    assign fetch_step = active && fetch_win && pix_pulse_in;
    assign phase      = phase_t'(nes_x_in[2:1]);

    assign comp       = {q_fv, q_v, q_h, q_vt, q_ht};
    assign comp_inc   = comp + (inc_addr_amt_in ? 15'd32 : 15'd1);

    // Attribute quadrant select: shift by 0/2/4/6 using coarse Y/X bit 1.
    assign at_shifted = vram_d_in >> {q_vt[1], q_ht[1], 1'b0};

    always_comb begin
        vram_a_out = {q_fv[1:0], q_v, q_h, q_vt, q_ht};
        if (active && fetch_win) begin
            case (phase)
                PH_NT:   vram_a_out = {2'b10, q_v, q_h, q_vt, q_ht};
                PH_AT:   vram_a_out = {2'b10, q_v, q_h, 4'b1111, q_vt[4:2], q_ht[4:2]};
                PH_PTL:  vram_a_out = {1'b0, bg_pt_sel_in, nt_byte, 1'b0, q_fv};
                PH_PTH:  vram_a_out = {1'b0, bg_pt_sel_in, nt_byte, 1'b1, q_fv};
                default: vram_a_out = {2'b10, q_v, q_h, q_vt, q_ht};
            endcase
        end
    end

    always_comb begin
        d_fv = q_fv;
        d_v  = q_v;
        d_h  = q_h;
        d_vt = q_vt;
        d_ht = q_ht;
        if (upd_cntrs_in) begin
            d_fv = fv_in;
            d_v  = v_in;
            d_h  = h_in;
            d_vt = vt_in;
            d_ht = ht_in;
        end else if (inc_addr_in && !active) begin
            {d_fv, d_v, d_h, d_vt, d_ht} = comp_inc;
        end else if (active && pix_pulse_in) begin
            if (fetch_win && (nes_x_in[2:0] == 3'd7)) begin
                d_ht = q_ht + 5'd1;
                if (q_ht == 5'd31)
                    d_h = ~q_h;
            end
            if (nes_x_in == 10'd255) begin
                d_fv = q_fv + 3'd1;
                if (q_fv == 3'd7) begin
                    // Row 29 is the last nametable row; 30/31 wrap without switching tables.
                    if (q_vt == 5'd29) begin
                        d_vt = 5'd0;
                        d_v  = ~q_v;
                    end else begin
                        d_vt = q_vt + 5'd1;
                    end
                end
            end
            if (nes_x_in == 10'd256) begin
                d_h  = h_in;
                d_ht = ht_in;
            end
            if ((nes_y_in == 10'd261) && (nes_x_in >= 10'd280) && (nes_x_in <= 10'd304)) begin
                d_fv = fv_in;
                d_v  = v_in;
                d_vt = vt_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_fv <= 3'd0;
            q_v  <= 1'b0;
            q_h  <= 1'b0;
            q_vt <= 5'd0;
            q_ht <= 5'd0;
        end else begin
            q_fv <= d_fv;
            q_v  <= d_v;
            q_h  <= d_h;
            q_vt <= d_vt;
            q_ht <= d_ht;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            nt_byte        <= 8'd0;
            at_byte        <= 2'd0;
            ptl_tmp        <= 8'd0;
            at_out         <= 2'd0;
            ptl_out        <= 8'd0;
            pth_out        <= 8'd0;
            tile_valid_out <= 1'b0;
        end else begin
            tile_valid_out <= fetch_step && (nes_x_in[2:0] == 3'd7);
            if (fetch_step) begin
                case (nes_x_in[2:0])
                    3'd1: nt_byte <= vram_d_in;
                    3'd3: at_byte <= at_shifted[1:0];
                    3'd5: ptl_tmp <= vram_d_in;
                    3'd7: begin
                        at_out  <= at_byte;
                        ptl_out <= ptl_tmp;
                        pth_out <= vram_d_in;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
